// File: rtl/game_state_ctrl.sv
// game_state_ctrl: lives, multi-wave level progression and sticky win/lose states.
// Emits a one-cycle level-start pulse for the invader block to reload its formation.
module game_state_ctrl #(
  parameter int N_INVADERS     = 20,
  parameter int LINE_W         = 4,
  parameter int GAME_OVER_LINE = 13,
  parameter int LIVES          = 3,
  parameter int LIVES_W        = 2,
  parameter int N_LEVELS       = 4,
  parameter int LEVEL_W        = 2,
  parameter int CLEAR_HOLD     = 50,
  parameter int HOLD_W         = 6
) (
  input  logic                  i_clk_25MHz,
  input  logic                  i_reset,
  input  logic [N_INVADERS-1:0] i_invaders_array,
  input  logic [LINE_W-1:0]     i_invaders_line,
  input  logic                  i_player_hit,
  input  logic                  i_frame_tick,
  input  logic                  i_start,
  output logic [1:0]            o_gameplay,
  output logic [LIVES_W-1:0]    o_lives,
  output logic [LEVEL_W-1:0]    o_level,
  output logic                  o_level_start,
  output logic                  o_life_lost
);
  typedef enum logic [1:0] {
    PLAYING     = 2'b00,
    YOU_WIN     = 2'b01,
    GAME_OVER   = 2'b10,
    LEVEL_CLEAR = 2'b11
  } state_t;
  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 start_q, start_d;
  logic                 lost_q, lost_d;
  logic                 last_level;
  assign last_level = level_q == LEVEL_W'(N_LEVELS - 1);
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    hold_d  = hold_q;
    start_d = 1'b0;
    lost_d  = 1'b0;
    case (state_q)
      PLAYING:
        // the cycle carrying the reload pulse still sees the old formation, so ignore it
        if (!start_q) begin
          if (i_invaders_line == LINE_W'(GAME_OVER_LINE)) state_d = GAME_OVER;
          else if (i_player_hit && lives_q <= LIVES_W'(1)) begin
            lives_d = '0;
            state_d = GAME_OVER;
          end else if (i_player_hit) begin
            lives_d = lives_q - 1'b1;
            lost_d  = 1'b1;
          end else if (i_invaders_array == '0) begin
            state_d = last_level ? YOU_WIN : LEVEL_CLEAR;
            hold_d  = HOLD_W'(CLEAR_HOLD);
          end
        end
      LEVEL_CLEAR:
        if (hold_q == '0) begin
          level_d = level_q + 1'b1;
          start_d = 1'b1;
          state_d = PLAYING;
        end else if (i_frame_tick) hold_d = hold_q - 1'b1;
      default:
        if (i_start) begin
          lives_d = LIVES_W'(LIVES);
          level_d = '0;
          start_d = 1'b1;
          state_d = PLAYING;
        end
    endcase
  end
  always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PLAYING;
      lives_q <= LIVES_W'(LIVES);
      level_q <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      start_q <= start_d;
      lost_q  <= lost_d;
    end
  end
  assign o_gameplay    = state_q;
  assign o_lives       = lives_q;
  assign o_level       = level_q;
  assign o_level_start = start_q;
  assign o_life_lost   = lost_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed stimulus with a behavioural game model compared every cycle.
module tb_game_state_ctrl;
  localparam int NI = 20, LW = 4, GOL = 13, LIVES = 3, LVW = 2, NLEV = 4, LEVW = 2, HOLD = 50, HW = 6;
  localparam int G_PLAY = 0, G_WIN = 1, G_OVER = 2, G_CLEAR = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] arr;
  logic [LW-1:0] line;
  logic hit, tick, start;
  logic [1:0] gameplay;
  logic [LVW-1:0] lives;
  logic [LEVW-1:0] level;
  logic level_start, life_lost;
  int checks = 0, failures = 0;
  bit cmp_on = 0;
  int m_mode, m_lives, m_level, m_ticks_left;
  bit m_pulse_start, m_pulse_lost;

  game_state_ctrl #(
    .N_INVADERS(NI), .LINE_W(LW), .GAME_OVER_LINE(GOL), .LIVES(LIVES), .LIVES_W(LVW),
    .N_LEVELS(NLEV), .LEVEL_W(LEVW), .CLEAR_HOLD(HOLD), .HOLD_W(HW)
  ) dut (
    .i_clk_25MHz(clk), .i_reset(rst_n), .i_invaders_array(arr), .i_invaders_line(line),
    .i_player_hit(hit), .i_frame_tick(tick), .i_start(start), .o_gameplay(gameplay),
    .o_lives(lives), .o_level(level), .o_level_start(level_start), .o_life_lost(life_lost)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // game rules applied to one sampled frame of inputs
  task automatic model_step();
    bit reloading = m_pulse_start;
    bit wave_gone = (arr == 0);
    bit invaded   = (line == GOL);
    m_pulse_start = 0;
    m_pulse_lost  = 0;
    if (m_mode == G_PLAY && !reloading) begin
      if (invaded) m_mode = G_OVER;
      else if (hit) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = G_OVER;
        else m_pulse_lost = 1;
      end else if (wave_gone) begin
        if (m_level + 1 == NLEV) m_mode = G_WIN;
        else begin
          m_mode = G_CLEAR;
          m_ticks_left = HOLD;
        end
      end
    end else if (m_mode == G_CLEAR) begin
      if (m_ticks_left == 0) begin
        m_level++;
        m_pulse_start = 1;
        m_mode = G_PLAY;
      end else if (tick) m_ticks_left--;
    end else if ((m_mode == G_WIN || m_mode == G_OVER) && start) begin
      m_lives = LIVES;
      m_level = 0;
      m_pulse_start = 1;
      m_mode = G_PLAY;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = G_PLAY;
      m_lives = LIVES;
      m_level = 0;
      m_ticks_left = 0;
      m_pulse_start = 0;
      m_pulse_lost = 0;
    end else model_step();
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      chk("cyc_gameplay", gameplay, m_mode);
      chk("cyc_lives", lives, m_lives);
      chk("cyc_level", level, m_level);
      chk("cyc_level_start", level_start, m_pulse_start);
      chk("cyc_life_lost", life_lost, m_pulse_lost);
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1; arr = '1; line = 0; hit = 0; tick = 0;
    @(posedge clk); #1;
    chk("start_pulse", level_start, 1);
    chk("start_gameplay", gameplay, G_PLAY);
    chk("start_lives", lives, LIVES);
    chk("start_level", level, 0);
    @(negedge clk);
    start = 0;
  endtask

  // holds frame ticks high for exactly HOLD cycles, then expects the next wave
  task automatic clear_wave(input int next_level);
    @(negedge clk);
    tick = 1;
    repeat (HOLD) @(negedge clk);
    tick = 0;
    chk("hold_still_clear", gameplay, G_CLEAR);
    chk("hold_no_pulse", level_start, 0);
    @(posedge clk); #1;
    chk("next_level", level, next_level);
    chk("next_level_pulse", level_start, 1);
    chk("next_level_play", gameplay, G_PLAY);
    @(posedge clk); #1;
    chk("guard_no_retrigger", gameplay, G_PLAY);
    chk("pulse_single", level_start, 0);
  endtask

  initial begin
    int exp_lives[3] = '{2, 1, 0};
    int exp_lost[3]  = '{1, 1, 0};
    rst_n = 1; arr = '1; line = 0; hit = 0; tick = 0; start = 0;
    #5 rst_n = 0;
    cmp_on = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_gameplay", gameplay, G_PLAY);
    chk("rst_lives", lives, 3);
    chk("rst_level", level, 0);
    chk("rst_no_pulse", level_start, 0);
    @(negedge clk);
    line = 13;
    @(posedge clk); #1;
    chk("line_game_over", gameplay, G_OVER);
    @(negedge clk);
    line = 0; arr = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("over_sticky", gameplay, G_OVER);
    chk("over_lives_kept", lives, 3);
    chk("model_over", m_mode, G_OVER);
    do_start();
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      hit = 1;
      @(posedge clk); #1;
      chk("hit_lives", lives, exp_lives[i]);
      chk("hit_life_lost", life_lost, exp_lost[i]);
      @(negedge clk);
      hit = 0;
    end
    chk("last_hit_over", gameplay, G_OVER);
    chk("model_lives_zero", m_lives, 0);
    do_start();
    @(negedge clk);
    arr = 0;
    @(posedge clk); #1;
    chk("enter_clear", gameplay, G_CLEAR);
    for (int l = 1; l < NLEV; l++) begin
      clear_wave(l);
      @(posedge clk); #1;
      chk("after_wave", gameplay, (l == NLEV - 1) ? G_WIN : G_CLEAR);
    end
    chk("model_level_top", m_level, 3);
    @(negedge clk);
    hit = 1; line = 13; tick = 1;
    repeat (20) @(negedge clk);
    chk("win_sticky", gameplay, G_WIN);
    chk("win_level", level, 3);
    hit = 0; line = 0; tick = 0;
    do_start();
    @(negedge clk);
    hit = 1;
    @(posedge clk); #1;
    chk("hit_from3", lives, 2);
    @(negedge clk);
    hit = 1; arr = 0;
    @(posedge clk); #1;
    chk("hit_wins_over_clear_lives", lives, 1);
    chk("hit_wins_over_clear_state", gameplay, G_PLAY);
    chk("hit_wins_over_clear_pulse", life_lost, 1);
    @(negedge clk);
    hit = 0;
    @(posedge clk); #1;
    chk("deferred_clear", gameplay, G_CLEAR);
    @(negedge clk);
    tick = 1;
    repeat (5) @(posedge clk);
    #7 rst_n = 0;
    #1;
    chk("async_rst_gameplay", gameplay, G_PLAY);
    chk("async_rst_lives", lives, 3);
    chk("async_rst_level", level, 0);
    chk("async_rst_start", level_start, 0);
    chk("async_rst_lost", life_lost, 0);
    tick = 0; arr = '1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("release_no_pulse", level_start, 0);
    chk("release_playing", gameplay, G_PLAY);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised successor to the single-level game-state tracker. Tracks player lives and level progression across multiple invader waves, and enforces sticky terminal states. Sits between the invader/collision logic and the display/scoring blocks. It issues a one-cycle level-start pulse that the invader block uses to reload its formation.

Parameters:
N_INVADERS, 20, width of the alive-invader bitmap
LINE_W, 4, width of invader descent-line index
GAME_OVER_LINE, 13, line index at which invaders reach the player
LIVES, 3, lives granted at game start (1..2^LIVES_W-1)
LIVES_W, 2, width of lives counter
N_LEVELS, 4, number of waves; clearing the last one wins (2..2^LEVEL_W)
LEVEL_W, 2, width of level counter
CLEAR_HOLD, 50, frame ticks spent in LEVEL_CLEAR before the next wave (>=1)
HOLD_W, 6, width of hold counter

Ports:
i_clk_25MHz  in  1  system clock
i_reset  in  1  asynchronous active-low reset
i_invaders_array  in  N_INVADERS  alive bitmap; all-zero means wave destroyed
i_invaders_line  in  LINE_W  current descent line of the formation
i_player_hit  in  1  one-cycle pulse: the player cannon was hit
i_frame_tick  in  1  one-cycle pulse per video frame
i_start  in  1  one-cycle pulse: restart request (debounced button)
o_gameplay  out  2  state: 00 PLAYING, 01 YOU_WIN, 10 GAME_OVER, 11 LEVEL_CLEAR
o_lives  out  LIVES_W  remaining lives
o_level  out  LEVEL_W  current wave index, 0-based
o_level_start  out  1  one-cycle pulse: reload invader formation
o_life_lost  out  1  one-cycle pulse: a life was deducted, game continues

Behaviour:
- Reset (i_reset=0, asynchronous): o_gameplay=PLAYING, o_lives=LIVES, o_level=0, hold counter=0, o_level_start=0, o_life_lost=0.
- All outputs are registered. Decisions take effect on the clock edge after the inputs are sampled (1-cycle latency).
- o_level_start and o_life_lost default to 0 every cycle unless set below.
- PLAYING, evaluated in priority order:
  1. In a cycle where o_level_start=1, the array, line and hit inputs are ignored and the state stays PLAYING. This is the reload guard.
  2. i_invaders_line==GAME_OVER_LINE -> GAME_OVER. Lives are unchanged.
  3. i_player_hit=1 and o_lives==1 -> o_lives=0, GAME_OVER, no o_life_lost pulse.
  4. i_player_hit=1 and o_lives>1 -> o_lives-1, o_life_lost=1, stay PLAYING. A simultaneous all-zero array is deferred to the next cycle.
  5. i_invaders_array==0 and o_level==N_LEVELS-1 -> YOU_WIN.
  6. i_invaders_array==0 otherwise -> LEVEL_CLEAR, hold counter=CLEAR_HOLD.
  - i_start is ignored in PLAYING.
- LEVEL_CLEAR:
  - Each i_frame_tick decrements the hold counter.
  - When the counter is 0 (on any cycle): o_level+1, o_level_start=1, state PLAYING.
  - Hits, line and i_start are ignored. Lives are preserved.
- YOU_WIN and GAME_OVER are sticky. No input other than i_start or reset leaves them.
- i_start=1 in YOU_WIN or GAME_OVER -> o_lives=LIVES, o_level=0, o_level_start=1, state PLAYING.
- Invariants:
  - Once GAME_OVER or YOU_WIN is entered, o_gameplay never returns to PLAYING without i_start or reset.
  - o_lives is never decremented below 0.
  - o_level never exceeds N_LEVELS-1.
  - The two output pulses are never high on consecutive cycles from the same event.
- Reset asserted mid-LEVEL_CLEAR or mid-pulse clears everything immediately. No pulse is emitted on reset release.
- The hold counter is HOLD_W bits and must hold CLEAR_HOLD. It does not wrap: it holds at 0 until the transition fires.

Test Plan:
- Reset, then array=20'hFFFFF, line=13 -> o_gameplay=10 next cycle; it stays 10 for 100 cycles with array=0, line=0; o_lives=3.
- Three i_player_hit pulses spaced 5 cycles apart, array nonzero -> o_lives 3->2->1 with o_life_lost pulses on the first two; the third hit gives o_lives=0, o_gameplay=10, no pulse.
- Array=0 at level 0 with CLEAR_HOLD=50 -> o_gameplay=11. After the 50th i_frame_tick the next cycle gives o_level=1, a single o_level_start pulse and o_gameplay=00; array still 0 in that pulse cycle does not re-trigger.
- Clear levels 0..3 in sequence -> after the level-3 clear o_gameplay=01 (not 11); i_start -> o_level=0, o_lives=3, o_level_start pulse, o_gameplay=00.
- Same cycle: i_player_hit=1, array=0, o_lives=2 -> o_lives=1, state 00; next cycle with array still 0 -> 11.
- Assert i_reset=0 asynchronously mid-LEVEL_CLEAR (between clock edges) -> outputs return to reset values before the next edge; no o_level_start on reset release.
